// File: rtl/text_buffer_if.sv
// Write, clear, status and read-port signals shared between draw,
// scan-out and the text buffer.
interface text_buffer_if;
  logic       WE;
  logic [4:0] CX;
  logic [3:0] CY;
  logic [7:0] CHAR;
  logic       CLR;
  logic       BUSY;
  logic       WR_DROP;
  logic       RD_EN;
  logic [4:0] RD_CX;
  logic [3:0] RD_CY;
  logic [7:0] RD_CHAR;
  logic       RD_VALID;

  modport master (
    output WE, CX, CY, CHAR, CLR,
    output RD_EN, RD_CX, RD_CY,
    input  BUSY, WR_DROP,
    input  RD_CHAR, RD_VALID
  );

  modport slave (
    input  WE, CX, CY, CHAR, CLR,
    input  RD_EN, RD_CX, RD_CY,
    output BUSY, WR_DROP,
    output RD_CHAR, RD_VALID
  );
endinterface

// File: rtl/text_buffer.sv
// COLS x ROWS character-cell RAM with a draw write port, a 512-cycle
// clear sweep and a 2-cycle read port for the scan-out stage.
module text_buffer #(
  parameter int         COLS       = 32,
  parameter int         ROWS       = 16,
  parameter logic [7:0] FILL_CHAR  = 8'h20,
  parameter bit         AUTO_CLEAR = 1'b1
) (
  input  logic          CLK,
  input  logic          NRST,
  text_buffer_if.slave  bus
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;
  localparam logic [0:0] S_RST   = AUTO_CLEAR ? S_CLEAR : S_IDLE;

  localparam logic [5:0] COLS_W = 6'(COLS);
  localparam logic [4:0] ROWS_W = 5'(ROWS);

  logic [7:0] mem_q [512];

  logic [0:0] state_q, state_d;
  logic [8:0] cnt_q, cnt_d;
  logic       wr_drop_q, wr_drop_d;

  logic       rd_en_q;
  logic       rd_oor_q;
  logic [7:0] rd_data_q;
  logic [7:0] rd_char_q;
  logic       rd_valid_q;

  logic       wr_in;
  logic       rd_in;
  logic       clr_in;

  logic       mem_we;
  logic [8:0] mem_addr;
  logic [7:0] mem_wdata;

  assign wr_in  = ({1'b0, bus.CX} < COLS_W)
               && ({1'b0, bus.CY} < ROWS_W);
  assign rd_in  = ({1'b0, bus.RD_CX} < COLS_W)
               && ({1'b0, bus.RD_CY} < ROWS_W);
  assign clr_in = ({1'b0, cnt_q[4:0]} < COLS_W)
               && ({1'b0, cnt_q[8:5]} < ROWS_W);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_drop_d = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {bus.CY, bus.CX};
    mem_wdata = bus.CHAR;
    unique case (state_q)
      S_IDLE: begin
        mem_we = bus.WE && wr_in;
        if (bus.CLR) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        // every count is stepped so the sweep length never depends on COLS/ROWS
        mem_we    = clr_in;
        mem_addr  = cnt_q;
        mem_wdata = FILL_CHAR;
        wr_drop_d = bus.WE && wr_in;
        cnt_d     = cnt_q + 9'd1;
        if (cnt_q == 9'd511) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // read samples the old word so a same-address write is not seen
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[mem_addr] <= mem_wdata;
    end
    if (bus.RD_EN) begin
      rd_data_q <= mem_q[{bus.RD_CY, bus.RD_CX}];
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q    <= S_RST;
      cnt_q      <= '0;
      wr_drop_q  <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_oor_q   <= 1'b0;
      rd_char_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_drop_q  <= wr_drop_d;
      rd_en_q    <= bus.RD_EN;
      if (bus.RD_EN) begin
        rd_oor_q <= !rd_in;
      end
      rd_valid_q <= rd_en_q;
      if (rd_en_q) begin
        rd_char_q <= rd_oor_q ? FILL_CHAR : rd_data_q;
      end
    end
  end

  assign bus.BUSY     = (state_q == S_CLEAR);
  assign bus.WR_DROP  = wr_drop_q;
  assign bus.RD_CHAR  = rd_char_q;
  assign bus.RD_VALID = rd_valid_q;

endmodule

// File: tb/tb_text_buffer.sv
// Scoreboard bench for text_buffer: a full-width instance and a
// COLS=20 instance driven side by side.
module tb_text_buffer;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  text_buffer_if a_if ();
  text_buffer_if b_if ();

  text_buffer #(
    .COLS(32), .ROWS(16),
    .FILL_CHAR(8'h20), .AUTO_CLEAR(1'b1)
  ) u_a (
    .CLK(clk), .NRST(nrst), .bus(a_if.slave)
  );

  text_buffer #(
    .COLS(20), .ROWS(16),
    .FILL_CHAR(8'h20), .AUTO_CLEAR(1'b1)
  ) u_b (
    .CLK(clk), .NRST(nrst), .bus(b_if.slave)
  );

  typedef struct {
    logic       we;
    logic [4:0] wx;
    logic [3:0] wy;
    logic [7:0] wc;
    logic       rd;
    logic [4:0] rx;
    logic [3:0] ry;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    int         due;
  } sb_t;

  sb_t qa[$];
  sb_t qb[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int drop_a = 0;
  int drop_b = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (a_if.WR_DROP === 1'b1) drop_a++;
    if (a_if.RD_VALID === 1'b1) begin
      if (qa.size() == 0) begin
        check("a_rd_spurious", 32'd1, 32'd0);
      end else begin
        e = qa.pop_front();
        check("a_rd_data", 32'(a_if.RD_CHAR), 32'(e.d));
        check("a_rd_latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  always @(negedge clk) begin
    sb_t e;
    if (b_if.WR_DROP === 1'b1) drop_b++;
    if (b_if.RD_VALID === 1'b1) begin
      if (qb.size() == 0) begin
        check("b_rd_spurious", 32'd1, 32'd0);
      end else begin
        e = qb.pop_front();
        check("b_rd_data", 32'(b_if.RD_CHAR), 32'(e.d));
        check("b_rd_latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic idle_a();
    a_if.WE = 1'b0; a_if.CX = '0; a_if.CY = '0;
    a_if.CHAR = '0; a_if.CLR = 1'b0;
    a_if.RD_EN = 1'b0; a_if.RD_CX = '0; a_if.RD_CY = '0;
  endtask

  task automatic idle_b();
    b_if.WE = 1'b0; b_if.CX = '0; b_if.CY = '0;
    b_if.CHAR = '0; b_if.CLR = 1'b0;
    b_if.RD_EN = 1'b0; b_if.RD_CX = '0; b_if.RD_CY = '0;
  endtask

  task automatic drive_a(input vec_t v);
    a_if.WE = v.we; a_if.CX = v.wx;
    a_if.CY = v.wy; a_if.CHAR = v.wc;
    a_if.RD_EN = v.rd; a_if.RD_CX = v.rx;
    a_if.RD_CY = v.ry;
    if (v.rd) qa.push_back('{d: v.exp, due: cyc + 2});
  endtask

  task automatic drive_b(input vec_t v);
    b_if.WE = v.we; b_if.CX = v.wx;
    b_if.CY = v.wy; b_if.CHAR = v.wc;
    b_if.RD_EN = v.rd; b_if.RD_CX = v.rx;
    b_if.RD_CY = v.ry;
    if (v.rd) qb.push_back('{d: v.exp, due: cyc + 2});
  endtask

  function automatic vec_t rd(input logic [4:0] x,
                              input logic [3:0] y,
                              input logic [7:0] e);
    vec_t v;
    v = '{1'b0, 5'd0, 4'd0, 8'h00, 1'b1, x, y, e};
    return v;
  endfunction

  function automatic vec_t wr(input logic [4:0] x,
                              input logic [3:0] y,
                              input logic [7:0] c);
    vec_t v;
    v = '{1'b1, x, y, c, 1'b0, 5'd0, 4'd0, 8'h00};
    return v;
  endfunction

  function automatic vec_t wrd(input logic [4:0] x,
                               input logic [3:0] y,
                               input logic [7:0] c,
                               input logic [4:0] rx,
                               input logic [3:0] ry,
                               input logic [7:0] e);
    vec_t v;
    v = '{1'b1, x, y, c, 1'b1, rx, ry, e};
    return v;
  endfunction

  task automatic wait_busy_a(output int n);
    n = 0;
    while (a_if.BUSY === 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic drain(input int cycles);
    idle_a();
    idle_b();
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    vec_t tbl[12];
    logic [7:0] last;
    int n;

    tbl[0]  = rd(5'd0, 4'd0, 8'h20);
    tbl[1]  = rd(5'd31, 4'd15, 8'h20);
    tbl[2]  = rd(5'd17, 4'd9, 8'h20);
    tbl[3]  = wr(5'd5, 4'd3, 8'h41);
    tbl[4]  = rd(5'd5, 4'd3, 8'h41);
    tbl[5]  = wrd(5'd7, 4'd2, 8'h42, 5'd7, 4'd2, 8'h20);
    tbl[6]  = rd(5'd7, 4'd2, 8'h42);
    tbl[7]  = wrd(5'd31, 4'd15, 8'h7E, 5'd0, 4'd0, 8'h20);
    tbl[8]  = rd(5'd31, 4'd15, 8'h7E);
    tbl[9]  = rd(5'd30, 4'd15, 8'h20);
    tbl[10] = wrd(5'd0, 4'd0, 8'h5A, 5'd5, 4'd3, 8'h41);
    tbl[11] = rd(5'd0, 4'd0, 8'h5A);

    idle_a();
    idle_b();
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(a_if.BUSY), 32'd1);
    check("rst_rd_valid", 32'(a_if.RD_VALID), 32'd0);
    check("rst_wr_drop", 32'(a_if.WR_DROP), 32'd0);
    check("rst_rd_char", 32'(a_if.RD_CHAR), 32'd0);
    check("rst_busy_b", 32'(b_if.BUSY), 32'd1);

    nrst = 1'b1;
    wait_busy_a(n);
    check("busy_len_reset", 32'(n), 32'd512);
    check("busy_b_done", 32'(b_if.BUSY), 32'd0);

    last = 8'h00;
    for (int i = 0; i < 12; i++) begin
      drive_a(tbl[i]);
      if (tbl[i].rd) last = tbl[i].exp;
      @(negedge clk);
    end
    drain(4);
    check("tbl_drained", 32'(qa.size()), 32'd0);
    check("rd_valid_low", 32'(a_if.RD_VALID), 32'd0);
    check("rd_char_hold", 32'(a_if.RD_CHAR), 32'(last));
    check("idle_no_drop", 32'(drop_a), 32'd0);

    a_if.CLR = 1'b1;
    @(negedge clk);
    a_if.CLR = 1'b0;
    check("clr_busy", 32'(a_if.BUSY), 32'd1);
    drop_a = 0;
    n = 0;
    while (a_if.BUSY === 1'b1 && n < 1000) begin
      a_if.WE   = (n == 0);
      a_if.CX   = 5'd1;
      a_if.CY   = 4'd1;
      a_if.CHAR = 8'h99;
      a_if.CLR  = (n == 200);
      @(negedge clk);
      n++;
    end
    idle_a();
    check("busy_len_clr", 32'(n), 32'd512);
    check("drop_once", 32'(drop_a), 32'd1);

    drive_a(rd(5'd1, 4'd1, 8'h20));
    @(negedge clk);
    drive_a(rd(5'd5, 4'd3, 8'h20));
    @(negedge clk);
    drive_a(rd(5'd31, 4'd15, 8'h20));
    @(negedge clk);
    drain(4);
    check("clr_drained", 32'(qa.size()), 32'd0);

    drop_b = 0;
    drive_b(wr(5'd25, 4'd2, 8'h33));
    @(negedge clk);
    drive_b(wr(5'd19, 4'd2, 8'h34));
    @(negedge clk);
    drive_b(rd(5'd25, 4'd2, 8'h20));
    @(negedge clk);
    drive_b(rd(5'd19, 4'd2, 8'h34));
    @(negedge clk);
    drive_b(rd(5'd18, 4'd2, 8'h20));
    @(negedge clk);
    drain(4);
    check("b_oor_no_drop", 32'(drop_b), 32'd0);
    check("b_drained", 32'(qb.size()), 32'd0);

    b_if.CLR = 1'b1;
    @(negedge clk);
    b_if.CLR = 1'b0;
    drive_b(wr(5'd25, 4'd2, 8'h35));
    @(negedge clk);
    idle_b();
    @(negedge clk);
    check("b_oor_busy_drop", 32'(drop_b), 32'd0);
    drive_b(wr(5'd3, 4'd3, 8'h36));
    @(negedge clk);
    idle_b();
    @(negedge clk);
    check("b_in_busy_drop", 32'(drop_b), 32'd1);

    a_if.CLR = 1'b1;
    @(negedge clk);
    a_if.CLR = 1'b0;
    repeat (100) @(negedge clk);
    check("mid_busy", 32'(a_if.BUSY), 32'd1);
    nrst = 1'b0;
    #1;
    check("rst_mid_busy", 32'(a_if.BUSY), 32'd1);
    check("rst_mid_valid", 32'(a_if.RD_VALID), 32'd0);
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    wait_busy_a(n);
    check("busy_len_restart", 32'(n), 32'd512);

    drive_a(rd(5'd31, 4'd15, 8'h20));
    @(negedge clk);
    drive_a(rd(5'd0, 4'd0, 8'h20));
    @(negedge clk);
    drain(4);
    check("end_drained", 32'(qa.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
